// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit DAC soft mute/unmute stage.
package tx_pkg;

   localparam int unsigned SAMPLE_W   = 16;
   localparam int unsigned GAIN_W     = 16;
   localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h8000;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      ON        = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_t;

   // One ramp update toward unity (up=1) or zero (up=0); step 0 jumps straight to the target.
   function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] g,
                                                   input logic [GAIN_W-1:0] step,
                                                   input logic              up);
      logic [GAIN_W:0]   sum;
      logic [GAIN_W-1:0] res;
      sum = (GAIN_W+1)'(g) + (GAIN_W+1)'(step);
      if (up) begin
         res = (step == '0 || sum >= (GAIN_W+1)'(UNITY_GAIN)) ? UNITY_GAIN : sum[GAIN_W-1:0];
      end else begin
         res = (step == '0 || step >= g) ? '0 : GAIN_W'(g - step);
      end
      return res;
   endfunction

endpackage

// File: rtl/dac_gain_lane.sv
// One DAC lane: registers sample and gain, then multiplies, rounds half up and saturates.
module dac_gain_lane
   import tx_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] din,
   input  logic [GAIN_W-1:0]   gain,
   output logic [SAMPLE_W-1:0] dout
);

   localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;

   logic signed [SAMPLE_W-1:0] din_q;
   logic        [GAIN_W-1:0]   gain_q;
   logic        [SAMPLE_W-1:0] dout_q;
   logic signed [PROD_W-1:0]   prod;
   logic signed [PROD_W-1:0]   rnd;
   logic        [SAMPLE_W-1:0] sat_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         din_q  <= '0;
         gain_q <= '0;
         dout_q <= '0;
      end else begin
         din_q  <= din;
         gain_q <= gain;
         dout_q <= sat_d;
      end
   end

   // Gain is unsigned Q1.15, so it is zero-extended before the signed multiply.
   always_comb begin
      prod = $signed(PROD_W'(din_q)) * $signed(PROD_W'({1'b0, gain_q}));
      rnd  = (prod + PROD_W'(33'sd16384)) >>> 15;
      if (rnd > PROD_W'(33'sd32767)) begin
         sat_d = 16'h7FFF;
      end else if (rnd < -PROD_W'(33'sd32768)) begin
         sat_d = 16'h8000;
      end else begin
         sat_d = rnd[SAMPLE_W-1:0];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/dac_soft_ramp.sv
// Soft mute/unmute: ramps a common Q1.15 gain between 0 and unity and applies it to every lane.
module dac_soft_ramp
   import tx_pkg::*;
#(
   parameter int unsigned NUMBER_OF_LINE = 8
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               tx_enable,
   input  logic [GAIN_W-1:0]                  ramp_step,
   input  logic [SAMPLE_W*NUMBER_OF_LINE-1:0] din,
   output logic [SAMPLE_W*NUMBER_OF_LINE-1:0] dout,
   output logic                               muted,
   output logic                               ramp_active,
   output logic [GAIN_W-1:0]                  gain_mon
);

   ramp_state_t       state_q, state_d;
   logic [GAIN_W-1:0] g_q, g_d;
   logic [GAIN_W-1:0] g_up, g_dn;
   logic              muted_q, ramp_active_q;

   assign g_up = gain_step(g_q, ramp_step, 1'b1);
   assign g_dn = gain_step(g_q, ramp_step, 1'b0);

   // Direction follows tx_enable every cycle; a reversal continues from the current gain.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      case (state_q)
         MUTED: begin
            if (tx_enable) begin
               g_d     = g_up;
               state_d = (g_up == UNITY_GAIN) ? ON : RAMP_UP;
            end
         end
         ON: begin
            if (!tx_enable) begin
               g_d     = g_dn;
               state_d = (g_dn == '0) ? MUTED : RAMP_DOWN;
            end
         end
         default: begin
            if (tx_enable) begin
               g_d     = g_up;
               state_d = (g_up == UNITY_GAIN) ? ON : RAMP_UP;
            end else begin
               g_d     = g_dn;
               state_d = (g_dn == '0) ? MUTED : RAMP_DOWN;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= MUTED;
         g_q           <= '0;
         muted_q       <= 1'b1;
         ramp_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         g_q           <= g_d;
         muted_q       <= (state_d == MUTED);
         ramp_active_q <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
      end
   end

   for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : g_lane
      dac_gain_lane u_lane (
         .clock (clock),
         .reset (reset),
         .din   (din[SAMPLE_W*k +: SAMPLE_W]),
         .gain  (g_q),
         .dout  (dout[SAMPLE_W*k +: SAMPLE_W])
      );
   end

   assign muted       = muted_q;
   assign ramp_active = ramp_active_q;
   assign gain_mon    = g_q;

endmodule

// File: tb/tb_dac_soft_ramp.sv
// Self-checking bench for dac_soft_ramp: directed steps plus randomized traffic against a gain/pipeline model.
module tb_dac_soft_ramp;

   localparam int unsigned NL = 8;
   localparam int unsigned DW = 16 * NL;
   localparam int UNITY = 32768;

   logic          clock = 1'b0;
   logic          reset;
   logic          tx_enable;
   logic [15:0]   ramp_step;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          muted;
   logic          ramp_active;
   logic [15:0]   gain_mon;

   int chk_total = 0;
   int chk_pass  = 0;

   // Reference: gain as an integer, a one-beat input stage, and the expected output beat.
   int            g_m;
   int            d1_g;
   logic [DW-1:0] d1_din;
   logic [DW-1:0] dout_m;

   dac_soft_ramp #(.NUMBER_OF_LINE(NL)) dut (
      .clock       (clock),
      .reset       (reset),
      .tx_enable   (tx_enable),
      .ramp_step   (ramp_step),
      .din         (din),
      .dout        (dout),
      .muted       (muted),
      .ramp_active (ramp_active),
      .gain_mon    (gain_mon)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] ref_lane(input logic [15:0] d, input int g);
      longint p;
      p = longint'($signed(d)) * longint'(g);
      p = (p + 64'sd16384) >>> 15;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      return 16'(p);
   endfunction

   function automatic logic [DW-1:0] fill(input logic [15:0] v);
      logic [DW-1:0] r;
      for (int k = 0; k < NL; k++) r[16*k +: 16] = v;
      return r;
   endfunction

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      chk_total++;
      assert (obs === exp) chk_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic checkv(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      chk_total++;
      assert (obs === exp) chk_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drive one beat, advance the model across the edge, then compare at the falling edge.
   task automatic cycle(input logic rst, input logic tx, input logic [15:0] st, input logic [DW-1:0] d);
      reset     = rst;
      tx_enable = tx;
      ramp_step = st;
      din       = d;
      @(posedge clock);
      if (rst) begin
         g_m    = 0;
         d1_g   = 0;
         d1_din = '0;
         dout_m = '0;
      end else begin
         for (int k = 0; k < NL; k++) dout_m[16*k +: 16] = ref_lane(d1_din[16*k +: 16], d1_g);
         d1_din = d;
         d1_g   = g_m;
         if (tx) g_m = (st == 0) ? UNITY : ((g_m + int'(st) > UNITY) ? UNITY : g_m + int'(st));
         else    g_m = (st == 0) ? 0     : ((g_m - int'(st) < 0)     ? 0     : g_m - int'(st));
      end
      @(negedge clock);
      check16("gain_mon", gain_mon, 16'(g_m));
      check16("muted", 16'(muted), 16'(g_m == 0));
      check16("ramp_active", 16'(ramp_active), 16'(g_m != 0 && g_m != UNITY));
      checkv("dout", dout, dout_m);
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic [15:0]   rs;
      logic          rt;
      int            run;

      // Reset, then a full-scale input while muted must stay silent.
      cycle(1'b1, 1'b0, 16'h1000, fill(16'h7FFF));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h1000, fill(16'h7FFF));
      checkv("muted_silent", dout, '0);

      // Linear ramp up with step 0x1000 reaches unity after 8 clocks.
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'h1000, fill(16'h4000));
      check16("ramp8_unity", gain_mon, 16'h8000);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1000, fill(16'h4000));
      checkv("settled_half", dout, fill(16'h4000));

      // Extremes at unity gain pass through unchanged.
      rd = '0;
      for (int k = 0; k < NL; k++) rd[16*k +: 16] = k[0] ? 16'h7FFF : 16'h8000;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1000, rd);
      checkv("unity_extremes", dout, rd);

      // Down to mute, up to 0x3000, then reverse mid-ramp.
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h1000, fill(16'h1234));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1000, fill(16'h1234));
      check16("at_3000", gain_mon, 16'h3000);
      cycle(1'b0, 1'b0, 16'h1000, fill(16'h1234));
      check16("rev_2000", gain_mon, 16'h2000);
      cycle(1'b0, 1'b0, 16'h1000, fill(16'h1234));
      cycle(1'b0, 1'b0, 16'h1000, fill(16'h1234));
      check16("rev_zero", gain_mon, 16'h0000);
      check16("rev_muted", 16'(muted), 16'd1);

      // Step 0 switches instantly.
      cycle(1'b0, 1'b1, 16'h0000, fill(16'h0100));
      check16("instant_unity", gain_mon, 16'h8000);
      cycle(1'b0, 1'b0, 16'h0000, fill(16'h0100));
      check16("instant_mute", gain_mon, 16'h0000);

      // Rounding at half gain: +1 rounds up to 1, -1 rounds to 0.
      cycle(1'b0, 1'b1, 16'h4000, '0);
      rd = '0;
      for (int k = 0; k < NL; k++) rd[16*k +: 16] = k[0] ? 16'hFFFF : 16'h0001;
      cycle(1'b0, 1'b1, 16'h4000, rd);
      cycle(1'b0, 1'b1, 16'h4000, '0);
      check16("round_pos", dout[15:0], 16'h0001);
      check16("round_neg", dout[31:16], 16'h0000);

      // Reset mid-ramp clears the gain and the pipeline.
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0800, fill(16'h7000));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0800, fill(16'h7000));
      cycle(1'b1, 1'b1, 16'h0800, fill(16'h7000));
      cycle(1'b0, 1'b0, 16'h0800, fill(16'h7000));
      checkv("post_reset_dout", dout, '0);

      // Toggling tx_enable every cycle.
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 16'h0C00, fill(16'h5555));
      for (int i = 0; i < 24; i++) cycle(1'b0, i[0], 16'h0C00, {$urandom, $urandom, $urandom, $urandom});

      // Randomized runs of tx_enable, step values and samples, with occasional resets.
      run = 0;
      rt  = 1'b0;
      rs  = 16'h1000;
      for (int i = 0; i < 400; i++) begin
         if (run == 0) begin
            run = int'($urandom_range(1, 20));
            rt  = 1'($urandom);
            case ($urandom_range(0, 5))
               0:       rs = 16'h0000;
               1:       rs = 16'h8000;
               2:       rs = 16'hFFFF;
               3:       rs = 16'($urandom_range(1, 64));
               default: rs = 16'($urandom);
            endcase
         end
         run--;
         if (($urandom & 32'h1) == 0) rs = 16'($urandom_range(0, 16'h3000));
         cycle(($urandom_range(0, 99) == 0), rt, rs, {$urandom, $urandom, $urandom, $urandom});
      end

      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
